cube_accumulate: RTL

//  Downstream consumer of the 3-stage cube pipeline. Tracks pipeline latency with
//  an enable-gated valid delay line, accumulates i_count aligned cube results

---
 rtl/cube_accumulate_pkg.sv | 13 +
 rtl/cube_accumulate_if.sv | 26 ++
 rtl/valid_delay.sv | 33 +++
 rtl/cube_accumulate.sv | 98 +++++++++
 4 files changed

// File: rtl/cube_accumulate_pkg.sv
// Shared types and default sizing for the cube accumulator slice.
package cube_accumulate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_LATENCY = 3;
    localparam int unsigned DEFAULT_ACC_W   = 16;

endpackage

// File: rtl/cube_accumulate_if.sv
// Command/result bundle between a custom-instruction host and cube_accumulate.
interface cube_accumulate_if
    import cube_accumulate_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W
);
    logic             i_start;
    logic [7:0]       i_count;
    logic             i_xValid;
    logic [7:0]       i_cube;
    logic [ACC_W-1:0] o_sum;
    logic             o_done;
    logic             o_busy;
    logic             o_overflow;

    modport master (
        output i_start, i_count, i_xValid, i_cube,
        input  o_sum, o_done, o_busy, o_overflow
    );

    modport slave (
        input  i_start, i_count, i_xValid, i_cube,
        output o_sum, o_done, o_busy, o_overflow
    );

endinterface

// File: rtl/valid_delay.sv
// Enable-gated shift register for a single valid bit; DEPTH=0 is a plain wire.
module valid_delay #(
    parameter int unsigned DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    sr_q <= '0;
                end else if (i_en) begin
                    sr_q[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign o_q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cube_accumulate.sv
// Sums i_count latency-aligned cube results, then pulses o_done for one enabled cycle.
// Build option: define CUBE_ACCUMULATE_SAT_EN for saturating adds with sticky o_overflow.
module cube_accumulate
    import cube_accumulate_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned ACC_W   = DEFAULT_ACC_W
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_clkEn,
    cube_accumulate_if.slave   bus
);

    state_t           state_q;
    logic [7:0]       remaining_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_next;
    logic             v_aligned;

    // Valid follows x through the same number of enabled stages as the cube pipeline.
    valid_delay #(
        .DEPTH (LATENCY)
    ) u_valid_delay (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_en   (i_clkEn),
        .i_d    (bus.i_xValid),
        .o_q    (v_aligned)
    );

`ifdef CUBE_ACCUMULATE_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           clip;
    logic           overflow_q;

    always_comb begin
        sum_wide = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, bus.i_cube};
        clip     = sum_wide[ACC_W];
        sum_next = clip ? '1 : sum_wide[ACC_W-1:0];
    end

    assign bus.o_overflow = overflow_q;
`else
    always_comb begin
        sum_next = sum_q + ACC_W'(bus.i_cube);
    end

    assign bus.o_overflow = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sum_q       <= '0;
`ifdef CUBE_ACCUMULATE_SAT_EN
            overflow_q  <= 1'b0;
`endif
        end else if (i_clkEn) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        remaining_q <= bus.i_count;
                        sum_q       <= '0;
`ifdef CUBE_ACCUMULATE_SAT_EN
                        overflow_q  <= 1'b0;
`endif
                        state_q     <= (bus.i_count == 8'd0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (v_aligned) begin
                        sum_q       <= sum_next;
                        remaining_q <= remaining_q - 8'd1;
`ifdef CUBE_ACCUMULATE_SAT_EN
                        overflow_q  <= overflow_q | clip;
`endif
                        if (remaining_q == 8'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sum  = sum_q;
    assign bus.o_done = (state_q == DONE);
    assign bus.o_busy = (state_q == ACCUM);

endmodule
